// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD controller.
// Holds the FSM state encoding, the power-on init ROM with its per-entry
// post-write delay selection, the pin-bus bit positions of the packed
// {RS, RW, E, D[7:0]} bus, and the long-execution command classifier.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        LOAD,
        SETUP,
        E_HIGH,
        HOLD,
        EXEC,
        IDLE
    } state_t;

    // Which post-write execution wait a transfer needs.
    typedef enum logic [1:0] {
        DLY_EXEC,
        DLY_LONG,
        DLY_INIT1
    } dly_sel_t;

    localparam int         INIT_LEN  = 7;
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

    localparam int PIN_RS = 10;
    localparam int PIN_RW = 9;
    localparam int PIN_E  = 8;

    // 8-bit interface, 2 lines, display on, clear, entry mode increment.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: return 8'h38;
            3'd4:                   return 8'h0C;
            3'd5:                   return 8'h01;
            default:                return 8'h06;
        endcase
    endfunction

    // The first function-set needs the extended settle time; the clear needs
    // the long execution time.
    function automatic dly_sel_t init_dly(input logic [2:0] idx);
        case (idx)
            3'd0:    return DLY_INIT1;
            3'd5:    return DLY_LONG;
            default: return DLY_EXEC;
        endcase
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) are the only slow
    // instructions.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Free-running delay counter for the LCD controller timing states.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : reload the count to zero (asserted on every state entry)
//   limit    : length of the current interval in cycles (must be >= 1)
//   done     : high on the last cycle of the interval (count == limit-1)
module lcd_delay_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = start ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only timing engine.
// Runs the power-on init sequence, then accepts command/data bytes over a
// valid/ready handshake and generates setup, enable pulse, hold and
// execution-wait timing on the packed pin bus.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   cmd_valid  : write request; cmd_ready: request can be accepted this cycle
//   cmd_rs     : 0 = instruction, 1 = data; cmd_data: byte to write
//   init_done  : init sequence finished (sticky until rst)
//   busy       : transfer, wait or init in progress
//   lcd_pins   : {RS, RW, E, D[7:0]}
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP   = 1000000,
    parameter int T_SETUP     = 4,
    parameter int T_EPULSE    = 16,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2500,
    parameter int T_EXEC_LONG = 100000,
    parameter int T_INIT1     = 250000,
    parameter int CNT_W       = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rs,
    input  logic [7:0]  cmd_data,
    output logic        init_done,
    output logic        busy,
    output logic [10:0] lcd_pins
);

    localparam logic [CNT_W-1:0] LIM_POWERUP = CNT_W'(T_POWERUP);
    localparam logic [CNT_W-1:0] LIM_SETUP   = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] LIM_EPULSE  = CNT_W'(T_EPULSE);
    localparam logic [CNT_W-1:0] LIM_HOLD    = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] LIM_EXEC    = CNT_W'(T_EXEC);
    localparam logic [CNT_W-1:0] LIM_LONG    = CNT_W'(T_EXEC_LONG);
    localparam logic [CNT_W-1:0] LIM_INIT1   = CNT_W'(T_INIT1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       init_done_q, init_done_d;
    logic       rs_q, rs_d;
    logic [7:0] d_q, d_d;
    dly_sel_t   sel_q, sel_d;
    logic       cap_rs_q, cap_rs_d;
    logic [7:0] cap_data_q, cap_data_d;
    dly_sel_t   cap_sel_q, cap_sel_d;
    logic       e_q, e_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;

    logic             accept;
    logic             cnt_start;
    logic             cnt_done;
    logic [CNT_W-1:0] limit;

    assign accept    = cmd_valid && ready_q;
    assign cnt_start = (state_d != state_q);

    lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk   (clk),
        .rst   (rst),
        .start (cnt_start),
        .limit (limit),
        .done  (cnt_done)
    );

    always_comb begin
        limit = CNT_W'(1);
        case (state_q)
            PWR_WAIT: limit = LIM_POWERUP;
            SETUP:    limit = LIM_SETUP;
            E_HIGH:   limit = LIM_EPULSE;
            HOLD:     limit = LIM_HOLD;
            EXEC: begin
                case (sel_q)
                    DLY_LONG:  limit = LIM_LONG;
                    DLY_INIT1: limit = LIM_INIT1;
                    default:   limit = LIM_EXEC;
                endcase
            end
            default:  limit = CNT_W'(1);
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PWR_WAIT: if (cnt_done) state_d = LOAD;
            LOAD:     state_d = SETUP;
            SETUP:    if (cnt_done) state_d = E_HIGH;
            E_HIGH:   if (cnt_done) state_d = HOLD;
            HOLD:     if (cnt_done) state_d = EXEC;
            EXEC: begin
                if (cnt_done) begin
                    if (!init_done_q && idx_q != INIT_LAST) state_d = LOAD;
                    else                                    state_d = IDLE;
                end
            end
            IDLE:     if (accept) state_d = LOAD;
            default:  state_d = PWR_WAIT;
        endcase
    end

    // Registered outputs follow the state being entered so they line up
    // exactly with the state register.
    always_comb begin
        e_d     = (state_d == E_HIGH);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // Byte capture, pin latching and init sequencing.
    always_comb begin
        idx_d       = idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        d_d         = d_q;
        sel_d       = sel_q;
        cap_rs_d    = cap_rs_q;
        cap_data_d  = cap_data_q;
        cap_sel_d   = cap_sel_q;

        if (accept) begin
            cap_rs_d   = cmd_rs;
            cap_data_d = cmd_data;
            cap_sel_d  = is_long_cmd(cmd_rs, cmd_data) ? DLY_LONG : DLY_EXEC;
        end

        if (state_q == LOAD) begin
            if (init_done_q) begin
                rs_d  = cap_rs_q;
                d_d   = cap_data_q;
                sel_d = cap_sel_q;
            end else begin
                rs_d  = 1'b0;
                d_d   = init_byte(idx_q);
                sel_d = init_dly(idx_q);
            end
        end

        if (state_q == EXEC && cnt_done && !init_done_q) begin
            if (idx_q == INIT_LAST) init_done_d = 1'b1;
            else                    idx_d       = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PWR_WAIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            d_q         <= '0;
            sel_q       <= DLY_EXEC;
            cap_rs_q    <= 1'b0;
            cap_data_q  <= '0;
            cap_sel_q   <= DLY_EXEC;
            e_q         <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            d_q         <= d_d;
            sel_q       <= sel_d;
            cap_rs_q    <= cap_rs_d;
            cap_data_q  <= cap_data_d;
            cap_sel_q   <= cap_sel_d;
            e_q         <= e_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        lcd_pins         = '0;
        lcd_pins[7:0]    = d_q;
        lcd_pins[PIN_E]  = e_q;
        lcd_pins[PIN_RW] = 1'b0;
        lcd_pins[PIN_RS] = rs_q;
    end

    assign cmd_ready = ready_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed testbench for lcd_hd44780_ctrl with scaled timing parameters.
module tb_lcd_hd44780_ctrl;

    localparam int T_POWERUP   = 100;
    localparam int T_SETUP     = 2;
    localparam int T_EPULSE    = 5;
    localparam int T_HOLD      = 2;
    localparam int T_EXEC      = 20;
    localparam int T_EXEC_LONG = 60;
    localparam int T_INIT1     = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_rs = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_ready;
    logic        init_done;
    logic        busy;
    logic [10:0] lcd_pins;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    int rises = 0;
    bit bad_ready = 1'b0;
    bit saw55 = 1'b0;
    logic e_prev = 1'b0;

    lcd_hd44780_ctrl #(
        .T_POWERUP   (T_POWERUP),
        .T_SETUP     (T_SETUP),
        .T_EPULSE    (T_EPULSE),
        .T_HOLD      (T_HOLD),
        .T_EXEC      (T_EXEC),
        .T_EXEC_LONG (T_EXEC_LONG),
        .T_INIT1     (T_INIT1),
        .CNT_W       (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .init_done (init_done),
        .busy      (busy),
        .lcd_pins  (lcd_pins)
    );

    always #5 clk = ~clk;

    // Pulse counter and sticky observers, sampled on the inactive edge.
    always @(negedge clk) begin
        if (lcd_pins[8] === 1'b1 && e_prev !== 1'b1) rises = rises + 1;
        e_prev = lcd_pins[8];
        if (cmd_ready === 1'b1 && init_done !== 1'b1) bad_ready = 1'b1;
        if (lcd_pins[7:0] === 8'h55) saw55 = 1'b1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits for one E pulse and checks gap, setup, pulse width and hold.
    // Consumes the falling sample and one more hold sample.
    task automatic do_pulse(input string tag, input logic rs, input logic [7:0] d, input int exp_gap);
        int low;
        int high;
        logic [10:0] p1;
        logic [10:0] p2;
        logic [10:0] exp_pins;
        exp_pins = {rs, 1'b0, 1'b0, d};
        low = 0;
        p1 = '0;
        p2 = '0;
        tick();
        while (lcd_pins[8] !== 1'b1 && low < 2000) begin
            p2 = p1;
            p1 = lcd_pins;
            low++;
            tick();
        end
        chk({tag, " rise"}, int'(lcd_pins[8]), 1);
        if (lcd_pins[8] !== 1'b1) return;
        chk({tag, " gap"}, low, exp_gap);
        chk({tag, " setup pins"}, int'(p2), int'(exp_pins));
        chk({tag, " pulse pins"}, int'(lcd_pins), int'(exp_pins | 11'h100));
        high = 0;
        while (lcd_pins[8] === 1'b1 && high < 100) begin
            high++;
            tick();
        end
        chk({tag, " width"}, high, T_EPULSE);
        chk({tag, " hold0"}, int'(lcd_pins), int'(exp_pins));
        tick();
        chk({tag, " hold1"}, int'(lcd_pins), int'(exp_pins));
    endtask

    task automatic wait_ready(input string tag, input int exp);
        int n;
        n = 0;
        tick();
        while (cmd_ready !== 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        chk({tag, " ready"}, int'(cmd_ready), 1);
        chk({tag, " exec wait"}, n, exp);
    endtask

    // Called on the negedge where rst has just been released.
    task automatic run_init(input string tag, input bit early);
        logic [7:0] rom [7];
        int gaps [7];
        int r0;
        int nz;
        rom  = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        gaps = '{2, 43, 23, 23, 23, 23, 63};
        r0 = rises;
        nz = 0;
        bad_ready = 1'b0;
        saw55 = 1'b0;
        if (early) begin
            cmd_valid = 1'b1;
            cmd_rs = 1'b1;
            cmd_data = 8'h55;
        end
        for (int i = 0; i < T_POWERUP; i++) begin
            tick();
            if (lcd_pins !== 11'h000) nz++;
        end
        chk({tag, " powerup pins zero"}, nz, 0);
        for (int i = 0; i < 7; i++) begin
            do_pulse($sformatf("%s pulse%0d", tag, i), 1'b0, rom[i], gaps[i]);
            if (i == 5) chk({tag, " init_done before last"}, int'(init_done), 0);
        end
        cmd_valid = 1'b0;
        wait_ready({tag, " last"}, T_EXEC);
        chk({tag, " init_done"}, int'(init_done), 1);
        chk({tag, " busy idle"}, int'(busy), 0);
        chk({tag, " pulse count"}, rises - r0, 7);
        chk({tag, " ready before init"}, int'(bad_ready), 0);
        if (early) chk({tag, " 0x55 on D"}, int'(saw55), 0);
    endtask

    // Called while cmd_ready is high; leaves the bench at the sample after accept.
    task automatic issue(input string tag, input logic rs, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_rs = rs;
        cmd_data = d;
        tick();
        cmd_valid = 1'b0;
        cmd_data = 8'hA5;
        chk({tag, " ready drop"}, int'(cmd_ready), 0);
        chk({tag, " busy"}, int'(busy), 1);
    endtask

    task automatic write_cmd(input string tag, input logic rs, input logic [7:0] d, input int exec);
        issue(tag, rs, d);
        do_pulse(tag, rs, d, T_SETUP);
        wait_ready(tag, exec);
    endtask

    initial begin
        int r0;
        int n;

        rst = 1'b1;
        repeat (3) tick();
        chk("reset pins", int'(lcd_pins), 0);
        chk("reset ready", int'(cmd_ready), 0);
        chk("reset init_done", int'(init_done), 0);
        chk("reset busy", int'(busy), 1);
        rst = 1'b0;
        run_init("init1", 1'b1);

        write_cmd("data41", 1'b1, 8'h41, T_EXEC);
        write_cmd("clear01", 1'b0, 8'h01, T_EXEC_LONG);
        write_cmd("ddram80", 1'b0, 8'h80, T_EXEC);
        write_cmd("home02", 1'b0, 8'h02, T_EXEC_LONG);
        write_cmd("entry04", 1'b0, 8'h04, T_EXEC);
        write_cmd("data01", 1'b1, 8'h01, T_EXEC);

        // Back-to-back with cmd_valid held high.
        r0 = rises;
        cmd_valid = 1'b1;
        cmd_rs = 1'b1;
        cmd_data = 8'h48;
        tick();
        cmd_data = 8'h49;
        chk("b2b ready drop", int'(cmd_ready), 0);
        do_pulse("b2b first", 1'b1, 8'h48, T_SETUP);
        do_pulse("b2b second", 1'b1, 8'h49, T_EXEC + 4);
        cmd_valid = 1'b0;
        wait_ready("b2b", T_EXEC);
        repeat (30) tick();
        chk("b2b pulse count", rises - r0, 2);
        chk("b2b idle ready", int'(cmd_ready), 1);

        // Reset while E is high.
        issue("rstmid", 1'b0, 8'h80);
        n = 0;
        while (lcd_pins[8] !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        chk("rstmid E high", int'(lcd_pins[8]), 1);
        rst = 1'b1;
        tick();
        chk("rstmid pins", int'(lcd_pins), 0);
        chk("rstmid ready", int'(cmd_ready), 0);
        chk("rstmid init_done", int'(init_done), 0);
        chk("rstmid busy", int'(busy), 1);
        rst = 1'b0;
        run_init("init2", 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
